dmul_sobol_nch: RTL and testbench

- N-channel deterministic stochastic multiplier; each channel forms the product stream of its own A and B operands.
- Each channel supports two modes:
  - unipolar: AND of the two streams.
  - bipolar: XNOR of the two streams.
- All channels share two internal Sobol (dimension-1) generators, clocked so that one full period covers every (rngA, rngB) pair exactly once.
- Used as the parametrised successor of the single-channel bipolar multiplier in the unary kernel library; it adds a start/busy/done run controller and mode select.

---
 rtl/dmul_sobol_nch.sv | 142 ++++++++++++++
 tb/tb_dmul_sobol_nch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmul_sobol_nch.sv
// N-channel deterministic stochastic multiplier driven by two shared Sobol generators.
// Define DMUL_SOBOL_CNT_EN to add per-channel ones counters on oCnt.
module dmul_sobol_nch #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       mode,
  input  logic [NCH*WIDTH-1:0]       iA,
  input  logic [NCH*WIDTH-1:0]       iB,
  output logic                       busy,
  output logic                       oValid,
  output logic [NCH-1:0]             oC,
`ifdef DMUL_SOBOL_CNT_EN
  output logic [NCH*(2*WIDTH+1)-1:0] oCnt,
`endif
  output logic                       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [NCH*WIDTH-1:0] opA;
  logic [NCH*WIDTH-1:0] opB;
  logic                 modeR;
  logic [WIDTH-1:0]     xA;
  logic [WIDTH-1:0]     nA;
  logic [WIDTH-1:0]     xB;
  logic [WIDTH-1:0]     nB;
  logic                 accept;
  logic                 lastCycle;
  logic [NCH-1:0]       aBit;
  logic [NCH-1:0]       bBit;

  assign accept    = (state == IDLE) && start && !stop;
  // Both indices all-ones marks the final pair of the full 2^(2*WIDTH) sweep.
  assign lastCycle = (&nA) && (&nB);

  // Direction vector selected by the lowest zero bit of the index. An all-ones
  // index flips the LSB, which returns x to 0 and closes the period.
  function automatic logic [WIDTH-1:0] sobolDir(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (!n[i]) begin
        v              = '0;
        v[WIDTH-1-i]   = 1'b1;
      end
    end
    return v;
  endfunction

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opA   <= '0;
      opB   <= '0;
      modeR <= 1'b0;
      xA    <= '0;
      nA    <= '0;
      xB    <= '0;
      nB    <= '0;
    end else if (stop) begin
      state <= IDLE;
      xA    <= '0;
      nA    <= '0;
      xB    <= '0;
      nB    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            opA   <= iA;
            opB   <= iB;
            modeR <= mode;
            xA    <= '0;
            nA    <= '0;
            xB    <= '0;
            nB    <= '0;
          end
        end
        RUN: begin
          xA <= xA ^ sobolDir(nA);
          nA <= nA + 1'b1;
          if (&nA) begin
            xB <= xB ^ sobolDir(nB);
            nB <= nB + 1'b1;
          end
          if (lastCycle) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    aBit = '0;
    bBit = '0;
    for (int k = 0; k < NCH; k++) begin
      aBit[k] = opA[k*WIDTH +: WIDTH] > xA;
      bBit[k] = opB[k*WIDTH +: WIDTH] > xB;
    end
  end

  assign oC     = (state == RUN) ? (modeR ? ~(aBit ^ bBit) : (aBit & bBit)) : '0;
  assign busy   = (state == RUN) || (state == DONE);
  assign oValid = (state == RUN);
  assign done   = (state == DONE);

`ifdef DMUL_SOBOL_CNT_EN
  localparam int CW = 2 * WIDTH + 1;

  logic [CW-1:0] cnt [NCH];

  // Counters hold through DONE/IDLE and after stop; only start or rst clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= cnt[k] + CW'(oC[k]);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : gCntOut
    assign oCnt[k*CW +: CW] = cnt[k];
  end
`endif

endmodule

// File: tb/tb_dmul_sobol_nch.sv
// Self-checking bench for dmul_sobol_nch (WIDTH=4, NCH=4): scoreboard of per-channel
// expected ones counts, popped and compared when done pulses.
module tb_dmul_sobol_nch;

  localparam int WIDTH  = 4;
  localparam int NCH    = 4;
  localparam int OPW    = NCH * WIDTH;
  localparam int CW     = 2 * WIDTH + 1;
  localparam int RUNLEN = 1 << (2 * WIDTH);

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           start = 1'b0;
  logic           stop  = 1'b0;
  logic           mode  = 1'b0;
  logic [OPW-1:0] iA    = '0;
  logic [OPW-1:0] iB    = '0;
  logic           busy;
  logic           oValid;
  logic [NCH-1:0] oC;
  logic           done;
`ifdef DMUL_SOBOL_CNT_EN
  logic [NCH*CW-1:0] oCnt;
`endif

  int checks   = 0;
  int failures = 0;
  int ones [NCH];
  int validCnt = 0;
  int doneCnt  = 0;
  int cyc      = 0;
  int unsigned expQ [$];
  int expX [8] = '{0, 8, 12, 4, 6, 14, 10, 2};

  dmul_sobol_nch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .iA     (iA),
    .iB     (iB),
    .busy   (busy),
    .oValid (oValid),
    .oC     (oC),
`ifdef DMUL_SOBOL_CNT_EN
    .oCnt   (oCnt),
`endif
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int expOnes(input logic m, input int a, input int b);
    int s;
    s = 1 << WIDTH;
    return m ? (a * b + (s - a) * (s - b)) : (a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic setOp(input int k, input int a, input int b);
    iA[k*WIDTH +: WIDTH] = WIDTH'(a);
    iB[k*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Pulses start for one edge; when a done is expected, the reference counts are queued.
  task automatic startRun(input bit expectDone);
    for (int k = 0; k < NCH; k++) ones[k] = 0;
    validCnt = 0;
    if (expectDone) begin
      for (int k = 0; k < NCH; k++)
        expQ.push_back(int'(expOnes(mode, int'(iA[k*WIDTH +: WIDTH]), int'(iB[k*WIDTH +: WIDTH]))));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic waitDone(input string tag);
    while (done !== 1'b1 && cyc < RUNLEN + 20) tick();
    check(tag, cyc, RUNLEN + 1);
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (oValid === 1'b1) begin
      validCnt++;
      for (int k = 0; k < NCH; k++) ones[k] += int'(oC[k]);
    end
    if (done === 1'b1) begin
      doneCnt++;
      check("valid_len", validCnt, RUNLEN);
      if (expQ.size() < NCH) begin
        check("sb_depth_at_done", expQ.size(), NCH);
      end else begin
        for (int k = 0; k < NCH; k++) begin
          int unsigned e;
          e = expQ.pop_front();
          check($sformatf("ones_ch%0d", k), ones[k], e);
`ifdef DMUL_SOBOL_CNT_EN
          check($sformatf("oCnt_ch%0d", k), oCnt[k*CW +: CW], e);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneBefore;

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_oValid", oValid, 0);
    check("rst_oC", oC, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Run 1: unipolar, first eight rngA values checked against the Sobol sequence.
    mode = 1'b0;
    setOp(0, 12, 4);
    setOp(1, 7, 9);
    setOp(2, 15, 0);
    setOp(3, 3, 15);
    startRun(1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rngA_%0d", i), dut.xA, expX[i]);
      tick();
    end
    waitDone("done_cycle_run1");
    check("done_busy", busy, 1);
    check("done_oValid", oValid, 0);
    tick();
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_done", done, 0);

    // Run 2: bipolar; a start with new operands mid-run and a start in DONE are ignored.
    mode = 1'b1;
    setOp(0, 12, 4);
    setOp(1, 15, 15);
    setOp(2, 0, 0);
    setOp(3, 0, 15);
    startRun(1'b1);
    while (cyc < 10) tick();
    start = 1'b1;
    mode  = 1'b0;
    iA    = OPW'($urandom);
    iB    = OPW'($urandom);
    tick();
    start = 1'b0;
    check("start_in_run_busy", busy, 1);
    waitDone("done_cycle_run2");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_busy", busy, 0);
    tick();
    check("start_in_done_stays_idle", busy, 0);

    // Run 3: stop at RUN cycle 100, then a full run.
    mode = 1'b0;
    setOp(0, 9, 11);
    setOp(1, 5, 2);
    setOp(2, 14, 13);
    setOp(3, 1, 1);
    startRun(1'b0);
    while (cyc < 100) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_oValid", oValid, 0);
    check("stop_oC", oC, 0);
    check("stop_valid_cycles", validCnt, 100);
`ifdef DMUL_SOBOL_CNT_EN
    check("stop_oCnt_held", oCnt[0 +: CW], ones[0]);
`endif
    doneBefore = doneCnt;
    repeat (5) tick();
    check("stop_no_done", doneCnt, doneBefore);
    startRun(1'b1);
    waitDone("done_cycle_run3");
    tick();

    // Run 4: asynchronous reset at RUN cycle 50, then a full bipolar run.
    mode = 1'b1;
    setOp(0, 6, 10);
    setOp(1, 8, 8);
    setOp(2, 13, 2);
    setOp(3, 4, 7);
    startRun(1'b0);
    while (cyc < 50) tick();
    doneBefore = doneCnt;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_oValid", oValid, 0);
    check("arst_oC", oC, 0);
    check("arst_done", done, 0);
`ifdef DMUL_SOBOL_CNT_EN
    check("arst_oCnt", oCnt, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_done", doneCnt, doneBefore);
    startRun(1'b1);
    waitDone("done_cycle_run4");
    tick();

    // start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    tick();
    check("start_stop_busy_next", busy, 0);
    check("start_stop_oValid", oValid, 0);

    check("sb_empty", expQ.size(), 0);
    check("done_total", doneCnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
